// File: rtl/seg7_digit_counter_if.sv
`default_nettype none
// ============================================================================
// Module      : seg7_digit_counter_if
// Description : Signal bundle between a controller/stimulus side (master)
//               and the seg7_digit_counter core (slave).
//   btn_i  : raw pushbutton, active-high, bouncy, asynchronous
//   dir_i  : count direction level, 1 = up, 0 = down, asynchronous
//   num_o  : current BCD digit 0..9 for the 7-segment decoder
//   tick_o : one-cycle pulse coincident with every num_o update
//   run_o  : 1 = counting, 0 = paused
// Revision    : 1.0 - initial release
// ============================================================================
interface seg7_digit_counter_if;
  logic       btn_i;
  logic       dir_i;
  logic [3:0] num_o;
  logic       tick_o;
  logic       run_o;

  modport master (output btn_i, dir_i, input num_o, tick_o, run_o);
  modport slave  (input btn_i, dir_i, output num_o, tick_o, run_o);
endinterface
`default_nettype wire

// File: rtl/seg7_digit_counter.sv
`default_nettype none
// ============================================================================
// Module      : seg7_digit_counter
// Description : Single BCD digit counter stepping once every TICK_DIV clocks.
//               A debounced pushbutton toggles run/pause; dir selects up or
//               down counting with 9<->0 wrap.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : seg7_digit_counter_if.slave (btn_i, dir_i in; num_o, tick_o,
//          run_o out)
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_digit_counter #(
  parameter int TICK_DIV        = 12000000,
  parameter int DEBOUNCE_CYCLES = 120000
) (
  input  wire                   clk,
  input  wire                   rst,
  seg7_digit_counter_if.slave   bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] CNT_MAX    = '1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  // The entry cycle counts as the first stable cycle and the deciding cycle
  // as the last, so the counter only has to cover the cycles in between.
  localparam int            DEB_THRESH = (DEBOUNCE_CYCLES > 2) ? DEBOUNCE_CYCLES - 2 : 0;
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_THRESH);

  typedef enum logic [1:0] {
    S_LOW       = 2'd0,
    S_WAIT_HIGH = 2'd1,
    S_HIGH      = 2'd2,
    S_WAIT_LOW  = 2'd3
  } deb_state_t;

  // Two-flop synchronizers
  logic btn_s1_q, btn_s2_q;
  logic dir_s1_q, dir_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1_q <= 1'b0;
      btn_s2_q <= 1'b0;
      dir_s1_q <= 1'b0;
      dir_s2_q <= 1'b0;
    end else begin
      btn_s1_q <= bus.btn_i;
      btn_s2_q <= btn_s1_q;
      dir_s1_q <= bus.dir_i;
      dir_s2_q <= dir_s1_q;
    end
  end

  // Debounce FSM
  deb_state_t    deb_st_q;
  logic [DW-1:0] deb_cnt_q;
  logic          press_q;
  logic          deb_done;

  assign deb_done = (deb_cnt_q >= DEB_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      deb_st_q  <= S_LOW;
      deb_cnt_q <= '0;
      press_q   <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (deb_st_q)
        S_LOW: begin
          if (btn_s2_q) begin
            deb_st_q  <= S_WAIT_HIGH;
            deb_cnt_q <= '0;
          end
        end
        S_WAIT_HIGH: begin
          if (!btn_s2_q) begin
            deb_st_q <= S_LOW;
          end else if (deb_done) begin
            deb_st_q <= S_HIGH;
            press_q  <= 1'b1;
          end else if (deb_cnt_q != CNT_MAX) begin
            deb_cnt_q <= deb_cnt_q + DW'(1);
          end
        end
        S_HIGH: begin
          if (!btn_s2_q) begin
            deb_st_q  <= S_WAIT_LOW;
            deb_cnt_q <= '0;
          end
        end
        S_WAIT_LOW: begin
          if (btn_s2_q) begin
            deb_st_q <= S_HIGH;
          end else if (deb_done) begin
            deb_st_q <= S_LOW;
          end else if (deb_cnt_q != CNT_MAX) begin
            deb_cnt_q <= deb_cnt_q + DW'(1);
          end
        end
        default: deb_st_q <= S_LOW;
      endcase
    end
  end

  // Prescaler, run flag and digit
  logic [PW-1:0] presc_q;
  logic          run_q;
  logic          tick_q;
  logic [3:0]    num_q;
  logic [3:0]    num_d;
  logic          term;

  // Terminal count uses the pre-toggle run flag, so a press landing on the
  // terminal cycle still produces its tick.
  assign term = run_q && (presc_q == PRESC_LAST);

  always_comb begin
    num_d = 4'd0;
    if (num_q > 4'd9) begin
      num_d = 4'd0;
    end else if (dir_s2_q) begin
      num_d = (num_q == 4'd9) ? 4'd0 : num_q + 4'd1;
    end else begin
      num_d = (num_q == 4'd0) ? 4'd9 : num_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      run_q   <= 1'b1;
      tick_q  <= 1'b0;
      num_q   <= 4'd0;
    end else begin
      tick_q <= term;
      if (run_q) begin
        presc_q <= term ? '0 : presc_q + PW'(1);
      end
      if (term) begin
        num_q <= num_d;
      end
      if (press_q) begin
        run_q <= ~run_q;
      end
    end
  end

  assign bus.num_o  = num_q;
  assign bus.tick_o = tick_q;
  assign bus.run_o  = run_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_digit_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_digit_counter
// Description : Self-checking bench for seg7_digit_counter (TICK_DIV=4,
//               DEBOUNCE_CYCLES=3) against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_digit_counter;
  localparam int TD = 4;
  localparam int DB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_digit_counter_if bus ();

  seg7_digit_counter #(
    .TICK_DIV       (TD),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model: digit value, position within the tick period, run flag,
  // accepted button level and length of the current disagreeing streak.
  int m_num, m_phase, m_run, m_tick, m_acc, m_len, m_pend;
  int m_b1, m_b2, m_d1, m_d2;
  logic dir_v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic b, input logic d);
    int sync_now;
    int dsync;
    if (r) begin
      m_num = 0; m_phase = 0; m_run = 1; m_tick = 0;
      m_acc = 0; m_len = 0; m_pend = 0;
      m_b1 = 0; m_b2 = 0; m_d1 = 0; m_d2 = 0;
    end else begin
      sync_now = m_b2;
      dsync    = m_d2;
      m_tick   = (m_run == 1 && m_phase == TD - 1) ? 1 : 0;
      if (m_run == 1) m_phase = (m_phase + 1) % TD;
      if (m_tick == 1) m_num = (dsync == 1) ? (m_num + 1) % 10 : (m_num + 9) % 10;
      if (m_pend == 1) m_run = 1 - m_run;
      m_pend = 0;
      // A level is accepted after DB consecutive samples disagreeing with it.
      if (sync_now != m_acc) begin
        m_len++;
        if (m_len >= DB) begin
          m_acc  = sync_now;
          m_len  = 0;
          m_pend = m_acc;
        end
      end else begin
        m_len = 0;
      end
      m_b2 = m_b1; m_b1 = int'(b);
      m_d2 = m_d1; m_d1 = int'(d);
    end
  endtask

  task automatic step(input logic r, input logic b, input logic d);
    rst       = r;
    bus.btn_i = b;
    bus.dir_i = d;
    @(posedge clk);
    model_update(r, b, d);
    #1;
    check("num",   32'(bus.num_o),  32'(m_num));
    check("tick",  32'(bus.tick_o), 32'(m_tick));
    check("run",   32'(bus.run_o),  32'(m_run));
    check("range", 32'(bus.num_o <= 4'd9), 32'd1);
  endtask

  task automatic press();
    repeat (5) step(1'b0, 1'b1, dir_v);
    repeat (8) step(1'b0, 1'b0, dir_v);
  endtask

  initial begin
    bit pat [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic prev_run;
    int   toggles;
    int   guard;
    logic rb, rd, rr;

    rst = 1'b1; bus.btn_i = 1'b0; bus.dir_i = 1'b1; dir_v = 1'b1;
    model_update(1'b1, 1'b0, 1'b1);

    // Reset and count up
    repeat (2) step(1'b1, 1'b0, 1'b1);
    check("rst_num", 32'(bus.num_o), 32'd0);
    check("rst_run", 32'(bus.run_o), 32'd1);
    repeat (44) step(1'b0, 1'b0, 1'b1);

    // Count down from reset
    dir_v = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    repeat (44) step(1'b0, 1'b0, 1'b0);

    // Bouncy press: exactly one toggle to paused
    dir_v = 1'b1;
    toggles  = 0;
    prev_run = bus.run_o;
    for (int i = 0; i < 17; i++) begin
      step(1'b0, (i < 9) ? pat[i] : 1'b0, dir_v);
      if (bus.run_o !== prev_run) toggles++;
      prev_run = bus.run_o;
    end
    check("bounce_toggles", 32'(toggles), 32'd1);
    check("bounce_paused",  32'(bus.run_o), 32'd0);
    repeat (20) step(1'b0, 1'b0, dir_v);

    // Resume from held prescaler value
    press();
    repeat (10) step(1'b0, 1'b0, dir_v);

    // Press pulse aligned with terminal count
    guard = 0;
    while (!(m_run == 1 && m_phase == 2) && guard < 16) begin
      step(1'b0, 1'b0, dir_v);
      guard++;
    end
    check("align_guard", 32'(guard < 16), 32'd1);
    repeat (6) step(1'b0, 1'b1, dir_v);
    check("coinc_tick", 32'(bus.tick_o), 32'd1);
    check("coinc_run",  32'(bus.run_o),  32'd0);
    repeat (12) step(1'b0, 1'b0, dir_v);

    // Reset mid-debounce with num=7
    press();
    guard = 0;
    while (m_num != 7 && guard < 100) begin
      step(1'b0, 1'b0, dir_v);
      guard++;
    end
    check("reach7", 32'(bus.num_o), 32'd7);
    repeat (3) step(1'b0, 1'b1, dir_v);
    step(1'b1, 1'b1, dir_v);
    check("rst_mid_num", 32'(bus.num_o), 32'd0);
    check("rst_mid_run", 32'(bus.run_o), 32'd1);
    repeat (12) step(1'b0, 1'b0, dir_v);
    check("rst_mid_stillrun", 32'(bus.run_o), 32'd1);

    // Randomized traffic
    rb = 1'b0; rd = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) rb = ~rb;
      if ($urandom_range(0, 19) == 0) rd = ~rd;
      rr = ($urandom_range(0, 199) == 0);
      step(rr, rb, rd);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_digit_counter.md
SEG7_DIGIT_COUNTER -- requirements
Module: seg7_digit_counter

Interface
REQ-001 SHALL have parameter TICK_DIV, default 12000000, meaning clock cycles per count step (1 Hz at 12 MHz); legal range >= 2.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 120000, meaning consecutive stable cycles required to accept a button change (10 ms at 12 MHz); legal range >= 1.
REQ-003 SHALL have port clk, input, 1, the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port btn_i, input, 1, raw pushbutton, asynchronous and bouncy; active-high; each accepted press toggles run/pause.
REQ-006 SHALL have port dir_i, input, 1, asynchronous level; 1 = count up, 0 = count down.
REQ-007 SHALL have port num_o, output, 4, current BCD digit 0..9, fed directly to the downstream 7-segment decoder num_i.
REQ-008 SHALL have port tick_o, output, 1, one-cycle pulse marking each num_o update.
REQ-009 SHALL have port run_o, output, 1, 1 = counting, 0 = paused.

Function
REQ-010 SHALL pass btn_i and dir_i each through a 2-flop synchronizer before any use; 2-cycle input latency.
REQ-011 SHALL debounce the synchronized button with a 4-state FSM: LOW, WAIT_HIGH, HIGH, WAIT_LOW.
REQ-012 LOW: sync=1 -> WAIT_HIGH with debounce counter cleared; else stay.
REQ-013 WAIT_HIGH: sync=0 -> LOW; sync=1 held for DEBOUNCE_CYCLES consecutive cycles (counting the entry cycle) -> HIGH, emitting a one-cycle internal press pulse on that transition.
REQ-014 HIGH: sync=0 -> WAIT_LOW with counter cleared; WAIT_LOW: sync=1 -> HIGH; sync=0 held DEBOUNCE_CYCLES cycles -> LOW; no pulse on release.
REQ-015 Debounce counter SHALL saturate and never wrap; width = clog2(DEBOUNCE_CYCLES+1).
REQ-016 SHALL toggle run_o on the clock edge following the press pulse.
REQ-017 Prescaler SHALL count 0..TICK_DIV-1 only while run_o=1, wrapping to 0 after TICK_DIV-1.
REQ-018 While paused the prescaler SHALL hold its value, not clear; resume continues from the held value.
REQ-019 tick_o SHALL be 1 exactly in the cycle after the prescaler was at TICK_DIV-1 with run_o=1; otherwise 0.
REQ-020 num_o SHALL change on the same edge that raises tick_o, so the new value and tick_o are visible together.
REQ-021 Up: num_o+1, with 9 wrapping to 0; down: num_o-1, with 0 wrapping to 9; direction = synchronized dir_i sampled on the updating edge.
REQ-022 num_o SHALL never hold 10..15; any such value, including from an upset, SHALL load 0 on the next tick.
REQ-023 Simultaneous press pulse and terminal count: the tick SHALL still occur (gated by the pre-toggle run_o); the toggle then applies.
REQ-024 Between ticks, num_o SHALL be stable with no glitch cycles.

Reset
REQ-025 rst=1 SHALL override all logic on that edge: num_o=0, tick_o=0, run_o=1, prescaler=0, debounce FSM=LOW, counter=0, synchronizer flops=0.
REQ-026 Reset mid-operation (mid-debounce, mid-prescale) SHALL discard partial progress; counting restarts a full TICK_DIV period after rst deasserts.
REQ-027 Inputs SHALL be ignored while rst=1.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=3)
REQ-028 After reset, btn_i=0 and dir_i=1: tick_o pulses every 4 cycles; num_o = 1,2,...,9,0,1; run_o=1 throughout.
REQ-029 dir_i=0 from reset: num_o = 9,8,...,0,9; num_o checked never > 9 in any cycle.
REQ-030 btn_i bouncing 1,0,1,0 at 1-cycle spacing, then held 1 for 5 cycles: exactly one run_o toggle to 0, at 2 (sync) + 3 (debounce) + 1 cycles after the stable-high start; tick_o stays 0 and num_o holds.
REQ-031 Pause at prescaler=2, wait 20 cycles, press again: the first tick after resume arrives 2 cycles after run_o returns to 1 (prescaler held, not cleared).
REQ-032 Press pulse aligned with prescaler=3 while running: tick_o=1 and num_o advances in that cycle; run_o=0 in the following cycle; no further ticks.
REQ-033 rst asserted for 1 cycle with num_o=7, mid-debounce: next cycle num_o=0, run_o=1; first tick 4 cycles after rst deasserts; the pending press is not honoured.
